// File: rtl/noc_credit_tx_if.sv
// Flit link bundle: upstream flit handshake plus the downstream router link.
// master = flit source and router stub; slave = the credit transmitter.
interface noc_credit_tx_if #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] in_data;
    logic [DEST_WIDTH-1:0] in_dest;
    logic                  in_is_tail;
    logic [FLIT_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0] dest_out;
    logic                  is_tail_out;
    logic                  send_out;
    logic                  credit_in;

    modport master (
        output in_valid, in_data, in_dest, in_is_tail, credit_in,
        input  in_ready, data_out, dest_out, is_tail_out, send_out
    );

    modport slave (
        input  in_valid, in_data, in_dest, in_is_tail, credit_in,
        output in_ready, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/noc_credit_tx.sv
// Credit-based NoC link transmitter: small flit queue, packet FSM, credit counter.
// Define NOC_CREDIT_TX_ERR_EN to build the sticky credit-overflow detector.
module noc_credit_tx #(
    parameter int unsigned FLIT_WIDTH        = 32,
    parameter int unsigned DEST_WIDTH        = 6,
    parameter int unsigned FLIT_BUFFER_DEPTH = 4,
    parameter int unsigned TX_QUEUE_DEPTH    = 2,
    localparam int unsigned CREDIT_WIDTH     = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    noc_credit_tx_if.slave          link,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    err_credit_ovf
);
    localparam int unsigned PTR_WIDTH = $clog2(TX_QUEUE_DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]    QUEUE_FULL = CNT_WIDTH'(TX_QUEUE_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic {StIdle, StInPkt} pkt_state_e;

    logic [FLIT_WIDTH-1:0] q_data [TX_QUEUE_DEPTH];
    logic [DEST_WIDTH-1:0] q_dest [TX_QUEUE_DEPTH];
    logic                  q_tail [TX_QUEUE_DEPTH];

    logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    push, launch, take_dest;
    pkt_state_e              state_q, state_d;

    logic [FLIT_WIDTH-1:0] data_out_q;
    logic [DEST_WIDTH-1:0] dest_out_q;
    logic                  tail_out_q, send_q;

    assign push   = link.in_valid & in_ready_q;
    assign launch = (cnt_q != '0) && (credit_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        if (launch) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        case ({push, launch})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
        // Registered from post-edge occupancy, so no path from in_valid.
        in_ready_d = (cnt_d != QUEUE_FULL);
    end

    always_comb begin
        credit_d = credit_q;
        if (launch && !link.credit_in) begin
            credit_d = credit_q - CREDIT_WIDTH'(1);
        end else if (link.credit_in && !launch && (credit_q != CREDIT_MAX)) begin
            credit_d = credit_q + CREDIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_noc) begin
        if (push) begin
            q_data[wr_ptr_q] <= link.in_data;
            q_dest[wr_ptr_q] <= link.in_dest;
            q_tail[wr_ptr_q] <= link.in_is_tail;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            credit_q   <= CREDIT_MAX;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            credit_q   <= credit_d;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (launch && !q_tail[rd_ptr_q]) state_d = StInPkt;
            StInPkt: if (launch && q_tail[rd_ptr_q])  state_d = StIdle;
        endcase
    end

    // Only the head flit (launched from idle) may change the link destination.
    always_comb begin
        take_dest = (state_q == StIdle);
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            send_q     <= 1'b0;
            data_out_q <= '0;
            dest_out_q <= '0;
            tail_out_q <= 1'b0;
        end else begin
            send_q <= launch;
            if (launch) begin
                data_out_q <= q_data[rd_ptr_q];
                tail_out_q <= q_tail[rd_ptr_q];
                if (take_dest) dest_out_q <= q_dest[rd_ptr_q];
            end
        end
    end

`ifdef NOC_CREDIT_TX_ERR_EN
    logic err_q;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            err_q <= 1'b0;
        end else if (link.credit_in && !launch && (credit_q == CREDIT_MAX)) begin
            err_q <= 1'b1;
        end
    end

    assign err_credit_ovf = err_q;
`else
    assign err_credit_ovf = 1'b0;
`endif

    assign link.in_ready    = in_ready_q;
    assign link.send_out    = send_q;
    assign link.data_out    = data_out_q;
    assign link.dest_out    = dest_out_q;
    assign link.is_tail_out = tail_out_q;
    assign credit_count     = credit_q;
endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed bench for noc_credit_tx with a flit scoreboard checked on every send_out.
module tb_noc_credit_tx;
    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  dest;
        logic        tail;
    } flit_t;

`ifdef NOC_CREDIT_TX_ERR_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] credit_count;
    logic       err_credit_ovf;

    int    n_cmp   = 0;
    int    n_err   = 0;
    int    n_sends = 0;
    int    cyc     = 0;
    int    send_cyc[$];
    flit_t sb[$];
    flit_t mon_exp;
    logic  m_in_pkt = 1'b0;
    logic [5:0] m_dest = '0;

    noc_credit_tx_if #(.FLIT_WIDTH(32), .DEST_WIDTH(6)) link ();

    noc_credit_tx #(
        .FLIT_WIDTH(32),
        .DEST_WIDTH(6),
        .FLIT_BUFFER_DEPTH(4),
        .TX_QUEUE_DEPTH(2)
    ) dut (
        .clk_noc(clk),
        .rst_noc_sync(rst),
        .link(link),
        .credit_count(credit_count),
        .err_credit_ovf(err_credit_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && link.send_out === 1'b1) begin
            n_sends++;
            send_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("spurious_send", link.send_out, 1'b0);
            end else begin
                mon_exp = sb.pop_front();
                check("data_out", link.data_out, mon_exp.data);
                check("dest_out", link.dest_out, mon_exp.dest);
                check("is_tail_out", link.is_tail_out, mon_exp.tail);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [5:0] dst, input logic tl);
        flit_t f;
        logic  done = 1'b0;
        link.in_valid   = 1'b1;
        link.in_data    = d;
        link.in_dest    = dst;
        link.in_is_tail = tl;
        for (int i = 0; i < 20 && !done; i++) begin
            if (link.in_ready === 1'b1) begin
                f.data = d;
                f.tail = tl;
                f.dest = m_in_pkt ? m_dest : dst;
                if (!m_in_pkt) m_dest = dst;
                m_in_pkt = !tl;
                sb.push_back(f);
                done = 1'b1;
            end
            step(1);
        end
        link.in_valid = 1'b0;
        check("push_accepted", done, 1'b1);
    endtask

    task automatic give_credit(input int n);
        repeat (n) begin
            link.credit_in = 1'b1;
            step(1);
            link.credit_in = 1'b0;
        end
    endtask

    task automatic wait_sends(input int target);
        for (int i = 0; i < 30 && n_sends < target; i++) step(1);
        check("send_total", n_sends, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        link.in_valid   = 1'b0;
        link.in_data    = '0;
        link.in_dest    = '0;
        link.in_is_tail = 1'b0;
        link.credit_in  = 1'b0;
        step(3);
        check("rst_send", link.send_out, 1'b0);
        check("rst_data", link.data_out, 32'h0);
        check("rst_dest", link.dest_out, 6'h0);
        check("rst_tail", link.is_tail_out, 1'b0);
        check("rst_ready", link.in_ready, 1'b0);
        check("rst_credit", credit_count, 3'd4);
        check("rst_err", err_credit_ovf, 1'b0);
        rst = 1'b0;
        step(1);
        check("ready_after_rst", link.in_ready, 1'b1);

        // Four single-flit packets drain the credits; a fifth waits in the queue.
        push(32'hA000_0001, 6'h01, 1'b1);
        check("lat_n1_send", link.send_out, 1'b0);
        check("lat_n1_credit", credit_count, 3'd4);
        push(32'hA000_0002, 6'h02, 1'b1);
        check("lat_n2_send", link.send_out, 1'b1);
        check("lat_n2_credit", credit_count, 3'd3);
        push(32'hA000_0003, 6'h03, 1'b1);
        push(32'hA000_0004, 6'h04, 1'b1);
        push(32'hA000_0005, 6'h05, 1'b1);
        step(4);
        check("burst_sends", n_sends, 4);
        check("burst_credit", credit_count, 3'd0);
        check("burst_back_to_back", send_cyc[3] - send_cyc[0], 3);

        // One returned credit releases exactly one held flit, two cycles later.
        link.credit_in = 1'b1;
        step(1);
        link.credit_in = 1'b0;
        check("c1_credit", credit_count, 3'd1);
        check("c1_no_send_yet", link.send_out, 1'b0);
        step(1);
        check("c1_send", link.send_out, 1'b1);
        check("c1_credit_back", credit_count, 3'd0);
        step(1);
        check("c1_send_pulse", link.send_out, 1'b0);
        check("c1_total", n_sends, 5);

        give_credit(4);
        check("refill_credit", credit_count, 3'd4);
        give_credit(1);
        check("ovf_saturate", credit_count, 3'd4);
        check("ovf_flag", err_credit_ovf, EXP_OVF);

        // Credit return coinciding with a launch leaves the count unchanged.
        push(32'hB000_0001, 6'h10, 1'b1);
        push(32'hB000_0002, 6'h11, 1'b1);
        step(3);
        check("pre_both_credit", credit_count, 3'd2);
        check("pre_both_sends", n_sends, 7);
        push(32'hB000_0003, 6'h12, 1'b1);
        link.credit_in = 1'b1;
        step(1);
        link.credit_in = 1'b0;
        check("both_send", link.send_out, 1'b1);
        check("both_credit", credit_count, 3'd2);
        step(2);
        check("both_credit_after", credit_count, 3'd2);

        // Multi-flit packet keeps the head destination; next head picks a fresh one.
        give_credit(2);
        push(32'hC000_0001, 6'h05, 1'b0);
        push(32'hC000_0002, 6'h1F, 1'b0);
        push(32'hC000_0003, 6'h2A, 1'b1);
        push(32'hC000_0004, 6'h11, 1'b1);
        wait_sends(12);
        check("pkt_credit", credit_count, 3'd0);
        give_credit(4);

        // Reset in the middle of a packet with two flits stuck in the queue.
        push(32'hD000_0001, 6'h03, 1'b0);
        push(32'hD000_0002, 6'h21, 1'b0);
        push(32'hD000_0003, 6'h22, 1'b0);
        push(32'hD000_0004, 6'h23, 1'b0);
        push(32'hD000_0005, 6'h24, 1'b0);
        push(32'hD000_0006, 6'h25, 1'b0);
        step(3);
        check("mid_full_ready", link.in_ready, 1'b0);
        check("mid_credit", credit_count, 3'd0);
        check("mid_sends", n_sends, 16);
        rst = 1'b1;
        sb.delete();
        m_in_pkt = 1'b0;
        step(1);
        check("mid_rst_send", link.send_out, 1'b0);
        check("mid_rst_ready", link.in_ready, 1'b0);
        check("mid_rst_credit", credit_count, 3'd4);
        check("mid_rst_err", err_credit_ovf, 1'b0);
        rst = 1'b0;
        step(1);
        check("post_rst_ready", link.in_ready, 1'b1);
        check("post_rst_credit", credit_count, 3'd4);
        step(5);
        check("post_rst_no_send", n_sends, 16);
        push(32'hE000_0001, 6'h07, 1'b1);
        wait_sends(17);
        check("post_rst_credit_used", credit_count, 3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
